// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, arbiter state and writeback request type for the CPU core.
package cpu_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef enum logic {RR_LSU_NEXT, RR_ALU_NEXT} rr_state_t;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write bitmap; an issue set beats a writeback clear on the same register.
module wb_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_set_valid,
    input  logic [AW-1:0]    i_set_rd,
    input  logic             i_clr_valid,
    input  logic [AW-1:0]    i_clr_rd,
    output logic [NREGS-1:0] o_pending
);
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        w_set[i_set_rd] = i_set_valid;
        w_clr[i_clr_rd] = i_clr_valid;
    end

    // bit 0 is masked so x0 can never look busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) o_pending <= '0;
        else          o_pending <= ((o_pending & ~w_clr) | w_set) & ~NREGS'(1);
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: round-robin ALU/LSU writeback arbiter with registered write port,
// forwarding tap and RAW scoreboard.
module regfile_writeback
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             wr_enable,
    output logic [AW-1:0]    rd_addr,
    output logic [XLEN-1:0]  rd_data,
    output logic             fwd_valid,
    output logic [AW-1:0]    fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [NREGS-1:0] pending
);
    rr_state_t       r_rr;
    logic            r_wr_enable;
    logic [AW-1:0]   r_rd_addr;
    logic [XLEN-1:0] r_rd_data;
    logic            w_conflict;
    logic            w_take;
    wb_req_t         w_req;

    assign w_conflict = alu_valid && lsu_valid;
    assign alu_ready  = alu_valid && (!lsu_valid || r_rr == RR_ALU_NEXT);
    assign lsu_ready  = lsu_valid && (!alu_valid || r_rr == RR_LSU_NEXT);
    assign w_take     = alu_ready || lsu_ready;
    assign w_req      = alu_ready ? wb_req_t'{rd: alu_rd, data: alu_data}
                                  : wb_req_t'{rd: lsu_rd, data: lsu_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr        <= RR_LSU_NEXT;
            r_wr_enable <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_wr_enable <= w_take && w_req.rd != '0;
            if (w_take) begin
                r_rd_addr <= w_req.rd;
                r_rd_data <= w_req.data;
            end
            // the loser of a conflict gets priority next time
            if (w_conflict) r_rr <= (r_rr == RR_LSU_NEXT) ? RR_ALU_NEXT : RR_LSU_NEXT;
        end
    end

    assign wr_enable = r_wr_enable;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign fwd_valid = r_wr_enable;
    assign fwd_rd    = r_rd_addr;
    assign fwd_data  = r_rd_data;

    wb_scoreboard u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_set_valid (issue_valid && issue_rd != '0),
        .i_set_rd    (issue_rd),
        .i_clr_valid (r_wr_enable),
        .i_clr_rd    (r_rd_addr),
        .o_pending   (pending)
    );
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench; accepted writes are queued and matched against the write port.
module tb_regfile_writeback;
    import cpu_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             alu_valid, alu_ready, lsu_valid, lsu_ready, issue_valid;
    logic [AW-1:0]    alu_rd, lsu_rd, issue_rd, rd_addr, fwd_rd;
    logic [XLEN-1:0]  alu_data, lsu_data, rd_data, fwd_data;
    logic             wr_enable, fwd_valid;
    logic [NREGS-1:0] pending;

    wb_req_t          q[$];
    int               n_chk = 0;
    int               n_err = 0;
    logic             m_rr = 1'b0;
    logic             m_wr_v = 1'b0;
    logic [AW-1:0]    m_wr_rd = '0;
    logic [NREGS-1:0] m_pend = '0;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wr_enable(wr_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .pending(pending)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wb_req_t e;
        if (reset_n && wr_enable) begin
            if (q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("rd_addr", 64'(rd_addr), 64'(e.rd));
                chk("rd_data", 64'(rd_data), 64'(e.data));
                chk("fwd", 64'({fwd_valid, fwd_rd, fwd_data}), 64'({1'b1, e.rd, e.data}));
            end
        end
    end

    // one clock cycle of stimulus, entered and left at posedge+1
    task automatic step(input logic av, input logic [AW-1:0] ar, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [AW-1:0] lr, input logic [XLEN-1:0] ld,
                        input logic iv, input logic [AW-1:0] ir, output logic ga, output logic gl);
        wb_req_t w;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
        issue_valid = iv; issue_rd = ir;
        @(negedge clk); #1;
        ga = av && (!lv || m_rr);
        gl = lv && (!av || !m_rr);
        chk("alu_ready", 64'(alu_ready), 64'(ga));
        chk("lsu_ready", 64'(lsu_ready), 64'(gl));
        chk("wr_enable", 64'(wr_enable), 64'(m_wr_v));
        chk("pending", 64'(pending), 64'(m_pend));
        if (m_wr_v) m_pend[m_wr_rd] = 1'b0;
        if (iv && ir != '0) m_pend[ir] = 1'b1;
        if (av && lv) m_rr = !m_rr;
        w.rd = ga ? ar : lr;
        w.data = ga ? ad : ld;
        m_wr_v = (ga || gl) && w.rd != '0;
        m_wr_rd = w.rd;
        if (m_wr_v) q.push_back(w);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic ga, gl;
        repeat (n) step(0, '0, '0, 0, '0, '0, 0, '0, ga, gl);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        alu_valid = 0; lsu_valid = 0; issue_valid = 0;
        q.delete();
        m_rr = 0; m_wr_v = 0; m_wr_rd = '0; m_pend = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin : main
        logic ga, gl;
        logic [3:0] g4;
        int ai, li, cyc, nwr;
        alu_valid = 0; lsu_valid = 0; issue_valid = 0;
        alu_rd = '0; lsu_rd = '0; issue_rd = '0; alu_data = '0; lsu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", 64'(wr_enable), 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_pend", 64'(pending), 64'd0);
        reset_n = 1'b1;
        idle(5);

        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, ga, gl);
        chk("single_wr", 64'({wr_enable, rd_addr, rd_data}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
        chk("single_fwd", 64'({fwd_valid, fwd_rd, fwd_data}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
        idle(1);

        do_reset();
        ai = 0; li = 0; cyc = 0; g4 = '0;
        while ((ai < 4 || li < 4) && cyc < 20) begin
            step(ai < 4, AW'(ai + 1), 32'hA000 + ai, li < 4, AW'(li + 11), 32'hB000 + li, 0, '0, ga, gl);
            if (cyc < 4) g4 = {g4[2:0], gl};
            if (ga) ai++;
            if (gl) li++;
            cyc++;
        end
        chk("grant_order", 64'(g4), 64'(4'b1010));
        chk("conflict_cycles", 64'(cyc), 64'd8);
        idle(2);

        step(0, '0, '0, 1, 5'd0, 32'h1234, 0, '0, ga, gl);
        chk("rd0_ready", 64'(gl), 64'd1);
        chk("rd0_wr", 64'(wr_enable), 64'd0);
        chk("rd0_pend", 64'(pending), 64'd0);
        idle(1);

        step(0, '0, '0, 0, '0, '0, 1, 5'd7, ga, gl);
        chk("pend7_set", 64'(pending[7]), 64'd1);
        step(1, 5'd7, 32'h77, 0, '0, '0, 0, '0, ga, gl);
        idle(1);
        chk("pend7_clr", 64'(pending[7]), 64'd0);
        step(1, 5'd7, 32'h78, 0, '0, '0, 0, '0, ga, gl);
        step(0, '0, '0, 0, '0, '0, 1, 5'd7, ga, gl);
        chk("pend7_set_wins", 64'(pending[7]), 64'd1);
        step(0, '0, '0, 0, '0, '0, 1, 5'd0, ga, gl);
        chk("issue_rd0", 64'(pending), 64'h80);
        step(1, 5'd7, 32'h79, 0, '0, '0, 0, '0, ga, gl);
        step(0, '0, '0, 0, '0, '0, 1, 5'd3, ga, gl);
        chk("set_clr_diff", 64'(pending), 64'h8);

        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, AW'(i + 1), $urandom, 0, '0, '0, 0, '0, ga, gl);
            if (wr_enable) nwr++;
        end
        chk("b2b_writes", 64'(nwr), 64'd8);
        idle(2);

        step(1, 5'd9, 32'h99, 0, '0, '0, 1, 5'd4, ga, gl);
        chk("pre_rst_wr", 64'(wr_enable), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_wr", 64'(wr_enable), 64'd0);
        chk("rst_async_pend", 64'(pending), 64'd0);
        do_reset();
        idle(3);
        chk("drain", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 32x32 register file: the only block that drives the file's write port (rd_addr, rd_data, wr_enable).
- Arbitrates results from two producers, the ALU and the LSU, into one registered write per cycle.
- Presents a same-cycle forwarding tap for decode.
- Keeps a pending-write scoreboard so issue logic can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of results and register contents.
- NREGS, 32, architectural register count; register 0 is hardwired zero.
- AW, 5, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- issue_valid  in  1  instruction issued with a destination register.
- issue_rd  in  AW  destination register to mark pending.
- wr_enable  out  1  register-file write strobe.
- rd_addr  out  AW  register-file write address.
- rd_data  out  XLEN  register-file write data.
- fwd_valid  out  1  forwarding tap valid; equal to wr_enable.
- fwd_rd  out  AW  forwarding tap address; equal to rd_addr.
- fwd_data  out  XLEN  forwarding tap data; equal to rd_data.
- pending  out  NREGS  scoreboard; bit i set means a write to register i is outstanding.

Behaviour:
- Reset (asynchronous, immediate): wr_enable=0, rd_addr=0, rd_data=0, pending=0, rr_state=LSU_NEXT.
- Reset mid-operation discards any queued write; an accepted result is lost with no write performed.
- Handshake: a transfer occurs when valid && ready at a clock edge.
- ready is combinational from valid and rr_state. The write port never back-pressures, so a lone valid producer is always accepted.
- Producers hold rd and data stable while valid && !ready.
- Arbitration, single producer valid: that producer is accepted.
- Arbitration, both valid (conflict): the channel named by rr_state wins; the other sees ready=0.
- rr_state toggles to the loser only on a conflict cycle; non-conflict cycles leave it unchanged. With reset state LSU_NEXT, the first conflict goes to the LSU.
- Latency: a result accepted in cycle N appears on wr_enable/rd_addr/rd_data throughout cycle N+1. The register file captures it at the edge ending N+1.
- Throughput: one write per cycle sustained.
- When no transfer occurs in cycle N, wr_enable=0 in cycle N+1. rd_addr and rd_data hold their previous values; they are don't-care but must not be X after reset.
- A result with rd=0 is accepted (ready asserted normally) but produces wr_enable=0 in N+1. pending is unaffected.
- Forwarding: fwd_* are wires to the registered write outputs, no extra flops. This covers the window in which the register file still returns the old value.
- Scoreboard set: issue_valid with issue_rd!=0 sets pending[issue_rd] at the edge ending the issue cycle. issue_rd=0 is ignored.
- Scoreboard clear: wr_enable=1 clears pending[rd_addr] at the edge ending the write cycle.
- Same register set and cleared at the same edge: set wins, because the new instruction's write is outstanding.
- Different registers set and cleared at the same edge: both take effect.
- pending[0] is constant 0.
- Writes to a register whose pending bit is already clear still occur; the scoreboard does not police producers.
- Out-of-order completion between ALU and LSU is permitted. When both target the same register, the later write wins.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, NREGS, AW constants.
  - The rr_state enum {RR_LSU_NEXT, RR_ALU_NEXT}.
  - A wb_req_t struct {rd, data}, reused by the producers.
- One natural sub-module: wb_scoreboard (pending bitmap with set/clear priority).
- Arbiter, output register and forwarding stay in the top module.

Test Plan:
- Reset release with all inputs idle -> wr_enable=0, pending=32'h0 for 5 cycles; assert reset_n low mid-write -> wr_enable drops to 0 immediately.
- alu_valid=1, rd=5, data=32'hDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle wr_enable=1, rd_addr=5, rd_data=32'hDEADBEEF, fwd_* equal.
- Both valid for 4 consecutive cycles from reset (ALU rd=1..4, LSU rd=11..14, each held until accepted) -> grant order LSU,ALU,LSU,ALU; writes to 11,1,12,2 on consecutive cycles; remaining requests drain next.
- lsu_valid=1, rd=0, data=32'h1234 -> lsu_ready=1; next cycle wr_enable=0; pending unchanged.
- issue_valid with rd=7 -> pending[7]=1; ALU writes rd=7 -> pending[7] clears after the write cycle. Then issue rd=7 in the same cycle as a write to 7 -> pending[7] remains 1.
- issue_valid with rd=0 -> pending stays 0. Back-to-back ALU writes on 8 cycles with rd=1..8 -> 8 consecutive wr_enable cycles, no bubbles.
